// File: rtl/io_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// io_prog_loader_pkg
// Shared types and default sizes for the serial program loader.
//   ld_state_t  : loader FSM states
//   LD_DATA_W   : default instruction word width
//   LD_ADDR_W   : default instruction memory address width
// -----------------------------------------------------------------------------
package io_prog_loader_pkg;

  localparam int LD_DATA_W = 16;
  localparam int LD_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } ld_state_t;

endpackage

// File: rtl/io_sync.sv
// -----------------------------------------------------------------------------
// io_sync
// STAGES-deep flop chain bringing one asynchronous pin into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset, loads RST_VAL into every stage
//   d     : asynchronous input pin
//   q     : synchronized output
// -----------------------------------------------------------------------------
module io_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state is always assigned with <= so every stage samples
  // the previous stage's value from before the edge, forming a true shift chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/io_prog_loader.sv
// -----------------------------------------------------------------------------
// io_prog_loader
// Receives instruction words bit-serially (MSB first) on three io pins and
// writes them into the core's instruction memory. Holds the core in reset while
// loading and releases it only after a clean load (whole words, no overflow).
// Ports:
//   wb_clk_i, wb_rst_n   : system clock, synchronous active-low reset
//   ser_clk_i            : async serial bit clock, data taken on its rising edge
//   ser_dat_i            : async serial data, MSB first
//   ser_cs_n_i           : async load frame enable, active-low
//   imem_we_o            : one-cycle instruction memory write strobe
//   imem_addr_o          : write address (valid with imem_we_o)
//   imem_wdata_o         : write data    (valid with imem_we_o)
//   core_rst_n_o         : core reset, active-low
//   busy_o               : load in progress
//   done_o               : last load completed cleanly (sticky)
//   err_o                : last load had a partial word or overflowed (sticky)
//   word_cnt_o           : words written in the current or last load
// -----------------------------------------------------------------------------
module io_prog_loader
  import io_prog_loader_pkg::*;
#(
  parameter int DATA_W      = LD_DATA_W,
  parameter int ADDR_W      = LD_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              ser_clk_i,
  input  logic              ser_dat_i,
  input  logic              ser_cs_n_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  logic ser_clk_s, ser_dat_s, ser_cs_n_s;
  logic ser_clk_d;
  logic bit_stb;

  ld_state_t         state;
  // Only the first DATA_W-1 bits need storing; the last bit joins the word
  // directly on its way to imem_wdata_o.
  logic [DATA_W-2:0] shreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic              ovf;

  io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(wb_clk_i), .rst_n(wb_rst_n), .d(ser_clk_i), .q(ser_clk_s)
  );

  io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dat (
    .clk(wb_clk_i), .rst_n(wb_rst_n), .d(ser_dat_i), .q(ser_dat_s)
  );

  // cs_n resets high so a reset never looks like the start of a frame.
  io_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(wb_clk_i), .rst_n(wb_rst_n), .d(ser_cs_n_i), .q(ser_cs_n_s)
  );

  // Data passes through a synchronizer of the same depth as the clock, so
  // ser_dat_s is aligned with the synced rising edge.
  assign bit_stb = ser_clk_s & ~ser_clk_d;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state        <= IDLE;
      ser_clk_d    <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      addr         <= '0;
      ovf          <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      core_rst_n_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      ser_clk_d <= ser_clk_s;
      imem_we_o <= 1'b0;

      unique case (state)
        IDLE, RUN, ERR: begin
          if (!ser_cs_n_s) begin
            state        <= SHIFT;
            addr         <= '0;
            word_cnt_o   <= '0;
            bit_cnt      <= '0;
            ovf          <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            core_rst_n_o <= 1'b0;
            busy_o       <= 1'b1;
          end
        end

        SHIFT: begin
          // Deassert is tested first so a coincident bit strobe is dropped.
          if (ser_cs_n_s) begin
            busy_o <= 1'b0;
            if (bit_cnt == '0 && !ovf) begin
              state        <= RUN;
              core_rst_n_o <= 1'b1;
              done_o       <= 1'b1;
            end else begin
              state        <= ERR;
              core_rst_n_o <= 1'b0;
              err_o        <= 1'b1;
            end
          end else if (bit_stb) begin
            shreg   <= {shreg[DATA_W-3:0], ser_dat_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= WRITE;
              // Strobe is registered here so it is high during the WRITE cycle.
              // word_cnt_o MSB set means 2^ADDR_W words are already written.
              imem_we_o    <= ~word_cnt_o[ADDR_W];
              imem_addr_o  <= addr;
              imem_wdata_o <= {shreg, ser_dat_s};
            end
          end
        end

        WRITE: begin
          if (!word_cnt_o[ADDR_W]) begin
            addr       <= addr + 1'b1;
            word_cnt_o <= word_cnt_o + 1'b1;
          end else begin
            ovf <= 1'b1;
          end
          bit_cnt <= '0;
          state   <= SHIFT;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
